// File: rtl/gps_sample_packer_pkg.sv
// Shared constants and types for the GPS sample packer: nibble layout,
// the default FIFO depth and the BYTE_FIRST tag position.
package gps_sample_packer_pkg;

    localparam int NIB_I1 = 3;
    localparam int NIB_I0 = 2;
    localparam int NIB_Q1 = 1;
    localparam int NIB_Q0 = 0;

    localparam int DEFAULT_FIFO_AW = 4;
    localparam int FIRST_TAG_BIT   = 8;
    localparam int ENTRY_W         = 9;

    typedef enum logic {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } phase_t;

endpackage

// File: rtl/gps_sample_packer_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/level status.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gps_sample_packer.sv
// Packs pairs of 4-bit GPS I/Q samples into bytes, buffers them in a FIFO
// for the SPI stage, and tracks overflow with a resync tag on the next byte.
module gps_sample_packer
    import gps_sample_packer_pkg::*;
#(
    parameter int FIFO_AW = DEFAULT_FIFO_AW,
    parameter int DROP_W  = 8
) (
    input  logic               MCU_CLK_25_000,
    input  logic               RESET_P,
    input  logic               SAMPLE_STB,
    input  logic               GPS_I0,
    input  logic               GPS_I1,
    input  logic               GPS_Q0,
    input  logic               GPS_Q1,
    output logic [7:0]         BYTE_DATA,
    output logic               BYTE_VALID,
    output logic               BYTE_FIRST,
    input  logic               BYTE_READY,
    output logic [FIFO_AW:0]   FIFO_LEVEL,
    output logic               OVERFLOW,
    output logic [DROP_W-1:0]  DROP_COUNT,
    input  logic               CLR_OVF
);

    phase_t              phase_q;
    phase_t              phase_d;
    logic [3:0]          hold_q;
    logic [3:0]          nibble;
    logic                resync_q;
    logic                push;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_din;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                ovf_q;
    logic [DROP_W-1:0]   drop_q;

    always_comb begin
        nibble         = '0;
        nibble[NIB_I1] = GPS_I1;
        nibble[NIB_I0] = GPS_I0;
        nibble[NIB_Q1] = GPS_Q1;
        nibble[NIB_Q0] = GPS_Q0;
    end

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET_P) begin
            phase_q <= PH_HIGH;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        push    = 1'b0;
        case (phase_q)
            PH_HIGH: if (SAMPLE_STB) phase_d = PH_LOW;
            PH_LOW: begin
                if (SAMPLE_STB) begin
                    push    = 1'b1;
                    phase_d = PH_HIGH;
                end
            end
            default: phase_d = PH_HIGH;
        endcase
    end

    // Full is taken from the pre-pop pointers, so a same-cycle pop never rescues a push.
    assign drop     = push && fifo_full;
    assign fifo_din = {resync_q, hold_q, nibble};

    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET_P) begin
            hold_q   <= '0;
            resync_q <= 1'b1;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (SAMPLE_STB && phase_q == PH_HIGH) begin
                hold_q <= nibble;
            end
            if (drop) begin
                resync_q <= 1'b1;
            end else if (push) begin
                resync_q <= 1'b0;
            end
            // A drop coinciding with a clear restarts the count at one.
            if (drop) begin
                ovf_q <= 1'b1;
                if (CLR_OVF) begin
                    drop_q <= DROP_W'(1);
                end else if (drop_q != '1) begin
                    drop_q <= drop_q + 1'b1;
                end
            end else if (CLR_OVF) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (MCU_CLK_25_000),
        .rst   (RESET_P),
        .push  (push),
        .pop   (BYTE_READY),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign BYTE_VALID = !fifo_empty;
    assign BYTE_DATA  = fifo_empty ? 8'h00 : fifo_dout[7:0];
    assign BYTE_FIRST = fifo_empty ? 1'b0  : fifo_dout[FIRST_TAG_BIT];
    assign OVERFLOW   = ovf_q;
    assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed checks of the GPS sample packer plus a random-READY scoreboard run.
module tb_gps_sample_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stb = 1'b0;
    logic       i0 = 1'b0, i1 = 1'b0, q0 = 1'b0, q1 = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_first;
    logic       byte_ready = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_ovf = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_bytes [16];
    logic [7:0] sb_q [$];

    always #20 clk = ~clk;

    gps_sample_packer #(
        .FIFO_AW (4),
        .DROP_W  (8)
    ) dut (
        .MCU_CLK_25_000 (clk),
        .RESET_P        (rst),
        .SAMPLE_STB     (stb),
        .GPS_I0         (i0),
        .GPS_I1         (i1),
        .GPS_Q0         (q0),
        .GPS_Q1         (q1),
        .BYTE_DATA      (byte_data),
        .BYTE_VALID     (byte_valid),
        .BYTE_FIRST     (byte_first),
        .BYTE_READY     (byte_ready),
        .FIFO_LEVEL     (fifo_level),
        .OVERFLOW       (overflow),
        .DROP_COUNT     (drop_count),
        .CLR_OVF        (clr_ovf)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_nib(input logic [3:0] nib);
        {i1, i0, q1, q0} = nib;
    endtask

    task automatic strobe(input logic [3:0] nib);
        stb = 1'b1;
        set_nib(nib);
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic pair(input logic [3:0] hi, input logic [3:0] lo);
        strobe(hi);
        idle(5);
        strobe(lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic rand_cycle(input logic s, input logic [3:0] nib);
        byte_ready = ($urandom_range(0, 9) < 7);
        stb = s;
        set_nib(nib);
        if (byte_valid && byte_ready) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected", 1, 0);
            else check_eq("sb_byte", int'(byte_data), int'(sb_q.pop_front()));
        end
        @(negedge clk);
        stb = 1'b0;
    endtask

    initial begin
        logic [3:0] hi, lo, hold, nib;
        int         budget;

        @(negedge clk);
        // Test 1: reset state and first pairs
        do_reset();
        check_eq("rst_valid", byte_valid, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_data", byte_data, 0);
        check_eq("rst_first", byte_first, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_drop", drop_count, 0);
        byte_ready = 1'b1;
        strobe(4'hA);
        idle(5);
        check_eq("t1_valid_before", byte_valid, 0);
        strobe(4'h5);
        check_eq("t1_valid", byte_valid, 1);
        check_eq("t1_data", byte_data, 8'hA5);
        check_eq("t1_first", byte_first, 1);
        @(negedge clk);
        check_eq("t1_popped", byte_valid, 0);
        idle(4);
        pair(4'h3, 4'hC);
        check_eq("t1b_data", byte_data, 8'h3C);
        check_eq("t1b_first", byte_first, 0);
        idle(5);

        // Test 2: fill, overflow by two, drain in order
        do_reset();
        byte_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hi = 4'(i);
            lo = ~hi;
            exp_bytes[i] = {hi, lo};
            pair(hi, lo);
            idle(5);
        end
        check_eq("t2_level16", fifo_level, 16);
        check_eq("t2_ovf_pre", overflow, 0);
        pair(4'hF, 4'hF);
        idle(5);
        pair(4'hE, 4'hE);
        idle(5);
        check_eq("t2_level", fifo_level, 16);
        check_eq("t2_drop", drop_count, 2);
        check_eq("t2_ovf", overflow, 1);
        check_eq("t2_head_first", byte_first, 1);
        check_eq("t2_head_stable", byte_data, exp_bytes[0]);
        byte_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t2_drain_data", byte_data, exp_bytes[i]);
            check_eq("t2_drain_first", byte_first, (i == 0) ? 1 : 0);
            @(negedge clk);
        end
        check_eq("t2_empty", byte_valid, 0);
        byte_ready = 1'b0;
        pair(4'h7, 4'h8);
        check_eq("t2_resync_data", byte_data, 8'h78);
        check_eq("t2_resync_first", byte_first, 1);
        byte_ready = 1'b1;
        idle(5);
        byte_ready = 1'b0;

        // Test 3: push while full with a same-cycle pop is still dropped
        pulse_clr();
        check_eq("t3_clr_drop", drop_count, 0);
        check_eq("t3_clr_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            hi = 4'(i);
            pair(hi, hi);
            idle(5);
        end
        check_eq("t3_full", fifo_level, 16);
        strobe(4'hE);
        idle(5);
        byte_ready = 1'b1;
        strobe(4'hD);
        byte_ready = 1'b0;
        check_eq("t3_level", fifo_level, 15);
        check_eq("t3_drop", drop_count, 1);
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_head", byte_data, 8'h11);
        check_eq("t3_head_first", byte_first, 0);
        idle(5);

        // Test 4: saturating drop count and clear-versus-drop priority
        pair(4'h9, 4'h9);
        idle(5);
        check_eq("t4_refill", fifo_level, 16);
        for (int i = 0; i < 300; i++) begin
            pair(4'h0, 4'h0);
            idle(5);
        end
        check_eq("t4_sat", drop_count, 255);
        check_eq("t4_ovf", overflow, 1);
        strobe(4'h1);
        idle(5);
        clr_ovf = 1'b1;
        strobe(4'h2);
        clr_ovf = 1'b0;
        check_eq("t4_clr_drop", drop_count, 1);
        check_eq("t4_clr_ovf", overflow, 1);
        pulse_clr();
        check_eq("t4_clr_only", drop_count, 0);
        check_eq("t4_clr_only_ovf", overflow, 0);

        // Test 5: reset mid-pair with queued bytes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pair(4'h4, 4'h4);
            idle(5);
        end
        check_eq("t5_level5", fifo_level, 5);
        strobe(4'hF);
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_valid", byte_valid, 0);
        check_eq("t5_level", fifo_level, 0);
        idle(5);
        pair(4'h1, 4'h2);
        check_eq("t5_data", byte_data, 8'h12);
        check_eq("t5_first", byte_first, 1);
        check_eq("t5_level1", fifo_level, 1);

        // Test 6: random READY with steady strobes against a scoreboard
        do_reset();
        sb_q.delete();
        hold = 4'h0;
        for (int s = 0; s < 10000; s++) begin
            nib = 4'($urandom_range(0, 15));
            if (s % 2 == 0) hold = nib;
            else sb_q.push_back({hold, nib});
            rand_cycle(1'b1, nib);
            for (int k = 0; k < 5; k++) rand_cycle(1'b0, 4'h0);
        end
        byte_ready = 1'b1;
        budget = 40;
        while (byte_valid && budget > 0) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected", 1, 0);
            else check_eq("sb_byte", int'(byte_data), int'(sb_q.pop_front()));
            @(negedge clk);
            budget--;
        end
        check_eq("t6_drain_timeout", byte_valid, 0);
        check_eq("t6_sb_left", sb_q.size(), 0);
        check_eq("t6_drop", drop_count, 0);
        check_eq("t6_ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
